// File: rtl/exc_commit_ctrl.sv
// Exception/ERTN commit controller for the WB stage. It prioritises the event
// sources, pulses the WB-to-CSR bus for one cycle, flushes, and redirects fetch.
module exc_commit_ctrl #(
    parameter int WB2CSR_LEN = 49
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  wb_valid,
    input  logic [31:0]           wb_pc,
    input  logic [4:0]            wb_exc,
    input  logic                  wb_ertn,
    input  logic                  has_int,
    input  logic [31:0]           ex_entry,
    input  logic [31:0]           ertn_entry,
    output logic [WB2CSR_LEN-1:0] csr_in_bus,
    output logic                  flush,
    output logic                  wb_commit,
    output logic                  wb_allowin,
    output logic                  redirect_valid,
    output logic [31:0]           redirect_pc,
    input  logic                  redirect_ready
);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_FLUSH    = 2'd1;
    localparam logic [1:0] S_REDIRECT = 2'd2;

    localparam logic [5:0] ECODE_INT  = 6'h00;
    localparam logic [5:0] ECODE_ADEF = 6'h08;
    localparam logic [5:0] ECODE_INE  = 6'h0D;
    localparam logic [5:0] ECODE_SYS  = 6'h0B;
    localparam logic [5:0] ECODE_BRK  = 6'h0C;
    localparam logic [5:0] ECODE_ALE  = 6'h09;

    logic [1:0]  state;
    logic [1:0]  state_nxt;
    logic        idle;
    logic        is_exc;
    logic        take;
    logic [5:0]  ecode_sel;

    logic        cap_ertn;
    logic [5:0]  cap_ecode;
    logic [8:0]  cap_esubcode;
    logic [31:0] cap_pc;
    logic [31:0] redirect_pc_q;

    assign idle   = (state == S_IDLE);
    assign is_exc = wb_valid & (has_int | (|wb_exc));
    assign take   = wb_valid & (has_int | (|wb_exc) | wb_ertn);

    // Interrupt outranks every synchronous exception; ERTN only wins when nothing else is set.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        ecode_sel = ECODE_INT;
        if (has_int)        ecode_sel = ECODE_INT;
        else if (wb_exc[0]) ecode_sel = ECODE_ADEF;
        else if (wb_exc[1]) ecode_sel = ECODE_INE;
        else if (wb_exc[2]) ecode_sel = ECODE_SYS;
        else if (wb_exc[3]) ecode_sel = ECODE_BRK;
        else if (wb_exc[4]) ecode_sel = ECODE_ALE;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:     if (take) state_nxt = S_FLUSH;
            S_FLUSH:    state_nxt = S_REDIRECT;
            S_REDIRECT: if (redirect_ready) state_nxt = S_IDLE;
            default:    state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state         <= S_IDLE;
            cap_ertn      <= 1'b0;
            cap_ecode     <= 6'd0;
            cap_esubcode  <= 9'd0;
            cap_pc        <= 32'd0;
            redirect_pc_q <= 32'd0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            state <= state_nxt;
            if (idle && take) begin
                cap_ertn     <= ~is_exc;
                cap_ecode    <= is_exc ? ecode_sel : 6'd0;
                cap_esubcode <= 9'd0;
                cap_pc       <= wb_pc;
            end
            if (state == S_FLUSH)
                redirect_pc_q <= cap_ertn ? ertn_entry : ex_entry;
        end
    end

    // Bus is decoded from state so an async reset during FLUSH removes the pulse at once.
    assign csr_in_bus = (state == S_FLUSH)
                      ? {cap_ertn, ~cap_ertn, cap_ecode, cap_esubcode, cap_pc}
                      : '0;

    assign flush          = idle ? take : 1'b1;
    assign wb_commit      = idle & wb_valid & ~take;
    assign wb_allowin     = idle;
    assign redirect_valid = (state == S_REDIRECT);
    assign redirect_pc    = redirect_pc_q;

endmodule

// File: tb/tb_exc_commit_ctrl.sv
// Self-checking bench for exc_commit_ctrl: directed vector table, hand-written
// backpressure/reset sequences, and random traffic against an event-timeline model.
module tb_exc_commit_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic        wb_valid;
    logic [31:0] wb_pc;
    logic [4:0]  wb_exc;
    logic        wb_ertn;
    logic        has_int;
    logic [31:0] ex_entry;
    logic [31:0] ertn_entry;
    logic [48:0] csr_in_bus;
    logic        flush;
    logic        wb_commit;
    logic        wb_allowin;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        redirect_ready;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    exc_commit_ctrl #(.WB2CSR_LEN(49)) dut (
        .clk            (clk),
        .resetn         (resetn),
        .wb_valid       (wb_valid),
        .wb_pc          (wb_pc),
        .wb_exc         (wb_exc),
        .wb_ertn        (wb_ertn),
        .has_int        (has_int),
        .ex_entry       (ex_entry),
        .ertn_entry     (ertn_entry),
        .csr_in_bus     (csr_in_bus),
        .flush          (flush),
        .wb_commit      (wb_commit),
        .wb_allowin     (wb_allowin),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .redirect_ready (redirect_ready)
    );

    // Event timeline model: age counts cycles since the detection cycle of the open event.
    bit          m_active;
    int          m_age;
    bit          m_ertn;
    logic [5:0]  m_ecode;
    logic [31:0] m_pc;
    logic [31:0] m_target;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [5:0] ref_ecode(input bit intr, input logic [4:0] exc);
        logic [5:0] codes [5] = '{6'h08, 6'h0D, 6'h0B, 6'h0C, 6'h09};
        if (intr) return 6'h00;
        for (int i = 0; i < 5; i++)
            if (exc[i]) return codes[i];
        return 6'h00;
    endfunction

    function automatic logic [48:0] bus_of(input bit ertn, input logic [5:0] ec, input logic [31:0] pc);
        return {ertn, ~ertn, ec, 9'd0, pc};
    endfunction

    task automatic sample_check();
        bit tk;
        @(negedge clk);
        if (!m_active) begin
            tk = wb_valid && (has_int || (|wb_exc) || wb_ertn);
            check("idle_flush",     flush, tk);
            check("idle_commit",    wb_commit, wb_valid && !tk);
            check("idle_allowin",   wb_allowin, 1);
            check("idle_rvalid",    redirect_valid, 0);
            check("idle_bus",       csr_in_bus, 0);
        end else if (m_age == 1) begin
            check("flush_flush",    flush, 1);
            check("flush_commit",   wb_commit, 0);
            check("flush_allowin",  wb_allowin, 0);
            check("flush_rvalid",   redirect_valid, 0);
            check("flush_bus",      csr_in_bus, bus_of(m_ertn, m_ecode, m_pc));
        end else begin
            check("redir_flush",    flush, 1);
            check("redir_commit",   wb_commit, 0);
            check("redir_allowin",  wb_allowin, 0);
            check("redir_rvalid",   redirect_valid, 1);
            check("redir_pc",       redirect_pc, m_target);
            check("redir_bus",      csr_in_bus, 0);
        end
    endtask

    task automatic advance();
        @(posedge clk);
        if (!m_active) begin
            if (wb_valid && (has_int || (|wb_exc) || wb_ertn)) begin
                m_active = 1;
                m_age    = 1;
                m_ertn   = !(has_int || (|wb_exc));
                m_ecode  = m_ertn ? 6'h00 : ref_ecode(has_int, wb_exc);
                m_pc     = wb_pc;
            end
        end else if (m_age == 1) begin
            m_target = m_ertn ? ertn_entry : ex_entry;
            m_age    = 2;
        end else if (redirect_ready) begin
            m_active = 0;
        end
        #1;
    endtask

    task automatic cycle();
        sample_check();
        advance();
    endtask

    task automatic clear_inputs();
        wb_valid = 0; wb_exc = 0; wb_ertn = 0; has_int = 0;
    endtask

    // Assert reset between edges, check outputs before any clock, then release on a negedge.
    task automatic async_reset(input string tag);
        resetn = 0;
        #1;
        check({tag, "_bus"},    csr_in_bus, 0);
        check({tag, "_rvalid"}, redirect_valid, 0);
        check({tag, "_rpc"},    redirect_pc, 0);
        check({tag, "_flush"},  flush, 0);
        m_active = 0;
        @(posedge clk);
        @(negedge clk);
        resetn = 1;
        advance();
    endtask

    typedef struct {
        logic [4:0] exc;
        bit         intr;
        bit         ertn;
        logic [5:0] ecode;
        bit         is_ertn;
    } vec_t;

    vec_t vecs [10];

    initial begin
        vecs[0] = '{5'b00100, 1'b0, 1'b0, 6'h0B, 1'b0};
        vecs[1] = '{5'b10011, 1'b1, 1'b0, 6'h00, 1'b0};
        vecs[2] = '{5'b10011, 1'b0, 1'b0, 6'h08, 1'b0};
        vecs[3] = '{5'b10000, 1'b0, 1'b0, 6'h09, 1'b0};
        vecs[4] = '{5'b00000, 1'b0, 1'b1, 6'h00, 1'b1};
        vecs[5] = '{5'b00000, 1'b1, 1'b1, 6'h00, 1'b0};
        vecs[6] = '{5'b00010, 1'b0, 1'b0, 6'h0D, 1'b0};
        vecs[7] = '{5'b01000, 1'b0, 1'b0, 6'h0C, 1'b0};
        vecs[8] = '{5'b01100, 1'b0, 1'b0, 6'h0B, 1'b0};
        vecs[9] = '{5'b10100, 1'b0, 1'b1, 6'h0B, 1'b0};

        m_active = 0; m_age = 0; m_ertn = 0; m_ecode = 0; m_pc = 0; m_target = 0;
        resetn = 0;
        clear_inputs();
        wb_pc = 0; ex_entry = 32'h1C008000; ertn_entry = 32'h1C000200; redirect_ready = 1;
        #2;
        check("rst_bus",    csr_in_bus, 0);
        check("rst_rvalid", redirect_valid, 0);
        check("rst_rpc",    redirect_pc, 0);
        check("rst_flush",  flush, 0);
        check("rst_commit", wb_commit, 0);
        @(negedge clk);
        resetn = 1;
        advance();

        foreach (vecs[i]) begin
            logic [31:0] pc;
            pc = 32'h1C000100 + 32'(i * 16);
            wb_valid = 1; wb_exc = vecs[i].exc; has_int = vecs[i].intr; wb_ertn = vecs[i].ertn;
            wb_pc = pc;
            sample_check();
            check("tbl_n_flush",  flush, 1);
            check("tbl_n_commit", wb_commit, 0);
            advance();
            clear_inputs();
            sample_check();
            check("tbl_bus", csr_in_bus, bus_of(vecs[i].is_ertn, vecs[i].ecode, pc));
            advance();
            sample_check();
            check("tbl_rvalid", redirect_valid, 1);
            check("tbl_rpc", redirect_pc, vecs[i].is_ertn ? 32'h1C000200 : 32'h1C008000);
            advance();
            sample_check();
            check("tbl_idle_allowin", wb_allowin, 1);
            check("tbl_idle_flush",   flush, 0);
            advance();
        end

        // Backpressure: redirect held for 5 cycles while a new SYS is presented and ignored.
        wb_valid = 1; wb_exc = 5'b00100; wb_pc = 32'h1C000100; redirect_ready = 0;
        cycle();
        clear_inputs();
        cycle();
        for (int k = 0; k < 5; k++) begin
            wb_valid = 1; wb_exc = 5'b00100; wb_pc = 32'h1C0004F0; ex_entry = 32'h1C00C000 + 32'(k);
            sample_check();
            check("bp_rpc",     redirect_pc, 32'h1C008000);
            check("bp_rvalid",  redirect_valid, 1);
            check("bp_allowin", wb_allowin, 0);
            check("bp_flush",   flush, 1);
            advance();
        end
        clear_inputs();
        redirect_ready = 1;
        cycle();
        for (int k = 0; k < 3; k++) begin
            sample_check();
            check("bp_after_bus",    csr_in_bus, 0);
            check("bp_after_allowin", wb_allowin, 1);
            advance();
        end
        ex_entry = 32'h1C008000;

        // Normal retirement stream, then an interrupt with no valid instruction.
        for (int k = 0; k < 10; k++) begin
            wb_valid = 1; wb_pc = 32'h1C001000 + 32'(4 * k);
            sample_check();
            check("norm_commit", wb_commit, 1);
            check("norm_flush",  flush, 0);
            check("norm_bus",    csr_in_bus, 0);
            advance();
        end
        clear_inputs();
        has_int = 1;
        for (int k = 0; k < 3; k++) begin
            sample_check();
            check("int_novalid_flush", flush, 0);
            advance();
        end
        has_int = 0;

        // Reset during FLUSH.
        wb_valid = 1; wb_exc = 5'b00100; wb_pc = 32'h1C000100;
        cycle();
        clear_inputs();
        async_reset("rst_flush_st");
        cycle();
        // Reset during REDIRECT with the handshake stalled.
        wb_valid = 1; wb_ertn = 1; wb_pc = 32'h1C000300; redirect_ready = 0;
        cycle();
        clear_inputs();
        cycle();
        sample_check();
        advance();
        async_reset("rst_redir_st");
        redirect_ready = 1;
        cycle();

        // Random traffic against the model.
        for (int k = 0; k < 400; k++) begin
            wb_valid       = ($urandom_range(0, 3) != 0);
            wb_exc         = ($urandom_range(0, 5) == 0) ? 5'($urandom) : 5'd0;
            has_int        = ($urandom_range(0, 9) == 0);
            wb_ertn        = ($urandom_range(0, 7) == 0);
            wb_pc          = $urandom;
            redirect_ready = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 3) == 0) ex_entry = $urandom;
            if ($urandom_range(0, 3) == 0) ertn_entry = $urandom;
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
